pc_branch: RTL and testbench

- Branch-target adder for the single-cycle/pipelined CPU datapath.
- Adds PC+4 to the sign-extended, pre-shifted branch offset to form the branch target.
- Feeds the PC-source mux.
- Provides a zero-latency combinational result plus a registered copy with valid and status flags for pipelined use.

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_adder.sv | 23 ++
 rtl/pc_branch.sv | 79 +++++++
 tb/tb_pc_branch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: definitions shared by the branch-target adder files.
//   PC_WIDTH    default datapath width of PC, offset and target
//   word_t      word-address type at the default width
//   ALIGN_MASK  value that target bits [1:0] must hold for a word-aligned target
package pc_pkg;

  localparam int PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] word_t;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/pc_adder.sv
// pc_adder: unsigned WIDTH-bit adder with carry-out.
//   i_a, i_b  operands (WIDTH)
//   o_sum     (i_a + i_b) mod 2^WIDTH
//   o_carry   bit WIDTH of the WIDTH+1-bit sum
module pc_adder
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_sum;

  // Zero-extend both operands so the carry lands in the top bit.
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum   = w_sum[WIDTH-1:0];
  assign o_carry = w_sum[WIDTH];

endmodule

// File: rtl/pc_branch.sv
// pc_branch: branch-target adder, target = PCplus4 + offset.
// Produces a zero-latency combinational target and a registered copy with
// valid, carry and misalignment flags.
//   clk           system clock, all state updates on rising edge
//   reset         synchronous, active-high
//   in_valid      operands valid; qualifies capture into the output register
//   PCplus4       current PC + 4
//   shifted       sign-extended branch offset, already shifted left by 2
//   pcbranch      combinational target
//   pcbranch_q    registered target
//   out_valid     pcbranch_q was captured on the previous edge
//   carry_q       registered carry-out of the add
//   misaligned_q  registered flag: target bits [1:0] are non-zero
// Build option PCBRANCH_INTERNAL_SHIFT_EN: shifted carries an unshifted word
// offset and the block shifts it left by 2 itself (top two bits dropped).
module pc_branch
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] PCplus4,
  input  logic [WIDTH-1:0] shifted,
  output logic [WIDTH-1:0] pcbranch,
  output logic [WIDTH-1:0] pcbranch_q,
  output logic             out_valid,
  output logic             carry_q,
  output logic             misaligned_q
);

  logic [WIDTH-1:0] w_offset;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] r_target;
  logic             r_valid;
  logic             r_carry;
  logic             r_misaligned;

`ifdef PCBRANCH_INTERNAL_SHIFT_EN
  // Word offset to byte offset; low bits are zero so alignment depends only on PCplus4.
  assign w_offset = {shifted[WIDTH-3:0], 2'b00};
`else
  assign w_offset = shifted;
`endif

  pc_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a     (PCplus4),
    .i_b     (w_offset),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign pcbranch = w_sum;

  // Reset wins over in_valid; without in_valid the data/flags hold and only valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_target     <= '0;
      r_valid      <= 1'b0;
      r_carry      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_target     <= w_sum;
        r_carry      <= w_carry;
        r_misaligned <= (w_sum[1:0] != ALIGN_MASK);
      end
    end
  end

  assign pcbranch_q   = r_target;
  assign out_valid    = r_valid;
  assign carry_q      = r_carry;
  assign misaligned_q = r_misaligned;

endmodule

// File: tb/tb_pc_branch.sv
// Scoreboard bench for pc_branch: the driver applies directed vectors on the
// falling edge, checks the combinational target, and queues the expected
// registered state; a monitor pops and compares after each rising edge.
module tb_pc_branch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] PCplus4;
  logic [31:0] shifted;
  logic [31:0] pcbranch;
  logic [31:0] pcbranch_q;
  logic        out_valid;
  logic        carry_q;
  logic        misaligned_q;

  pc_branch #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .PCplus4      (PCplus4),
    .shifted      (shifted),
    .pcbranch     (pcbranch),
    .pcbranch_q   (pcbranch_q),
    .out_valid    (out_valid),
    .carry_q      (carry_q),
    .misaligned_q (misaligned_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] sh;
    logic [31:0] comb;
    logic [31:0] q;
    logic        v;
    logic        c;
    logic        m;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] q;
    logic        v;
    logic        c;
    logic        m;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic vld, input logic [31:0] pc, input logic [31:0] sh,
                     input logic [31:0] comb, input logic [31:0] q, input logic v, input logic c,
                     input logic m);
    vec_t t;
    t.rst = rst; t.vld = vld; t.pc = pc; t.sh = sh; t.comb = comb;
    t.q = q; t.v = v; t.c = c; t.m = m;
    vecs.push_back(t);
  endtask

  // Monitor: one expected record per driven cycle, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pcbranch_q",   e.idx, pcbranch_q,           e.q);
      chk("out_valid",    e.idx, {31'b0, out_valid},    {31'b0, e.v});
      chk("carry_q",      e.idx, {31'b0, carry_q},      {31'b0, e.c});
      chk("misaligned_q", e.idx, {31'b0, misaligned_q}, {31'b0, e.m});
    end
  end

  initial begin
    exp_t e;
    int   budget;
    reset = 1'b1; in_valid = 1'b0; PCplus4 = '0; shifted = '0;

`ifdef PCBRANCH_INTERNAL_SHIFT_EN
    //   rst vld PCplus4        shifted        comb           q              v  c  m
    add(1, 0, 32'h0,          32'h0,          32'h0,         32'h0,         0, 0, 0);
    add(0, 1, 32'h4,          32'h1,          32'h8,         32'h8,         1, 0, 0);
    add(0, 1, 32'h5,          32'h1,          32'h9,         32'h9,         1, 0, 1);
    add(0, 1, 32'h10,         32'hFFFF_FFFF,  32'hC,         32'hC,         1, 1, 0);
    add(0, 1, 32'h8,          32'hC000_0001,  32'hC,         32'hC,         1, 0, 0);
    add(0, 0, 32'h8,          32'h2,          32'h10,        32'hC,         0, 0, 0);
`else
    add(1, 0, 32'h0,          32'h0,          32'h0,         32'h0,         0, 0, 0);
    add(0, 1, 32'h4,          32'h4,          32'h8,         32'h8,         1, 0, 0);
    add(0, 1, 32'h8,          32'hC,          32'h14,        32'h14,        1, 0, 0);
    add(0, 1, 32'h20,         32'hFFFF_FFF0,  32'h10,        32'h10,        1, 1, 0);
    add(0, 1, 32'hFFFF_FFFC,  32'h8,          32'h4,         32'h4,         1, 1, 0);
    add(0, 1, 32'h6,          32'h0,          32'h6,         32'h6,         1, 0, 1);
    add(0, 0, 32'h100,        32'h3,          32'h103,       32'h6,         0, 0, 1);
    add(0, 1, 32'h1000,       32'h10,         32'h1010,      32'h1010,      1, 0, 0);
    add(0, 1, 32'h2001,       32'h2,          32'h2003,      32'h2003,      1, 0, 1);
    add(0, 0, 32'h0,          32'h0,          32'h0,         32'h2003,      0, 0, 1);
    add(0, 0, 32'h40,         32'h4,          32'h44,        32'h2003,      0, 0, 1);
    add(1, 1, 32'h44,         32'h8,          32'h4C,        32'h0,         0, 0, 0);
    add(0, 0, 32'h44,         32'h8,          32'h4C,        32'h0,         0, 0, 0);
    add(0, 1, 32'h8000_0000,  32'h8000_0000,  32'h0,         32'h0,         1, 1, 0);
    add(0, 1, 32'hFFFF_FFFF,  32'h2,          32'h1,         32'h1,         1, 1, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset    = vecs[i].rst;
      in_valid = vecs[i].vld;
      PCplus4  = vecs[i].pc;
      shifted  = vecs[i].sh;
      e.idx = i; e.q = vecs[i].q; e.v = vecs[i].v; e.c = vecs[i].c; e.m = vecs[i].m;
      sbq.push_back(e);
      #1;
      chk("pcbranch", i, pcbranch, vecs[i].comb);
    end

    @(negedge clk);
    in_valid = 1'b0;
    budget = 10;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
